// File: rtl/imem_stream_loader.sv
// Byte-stream loader for the instruction memory write port; holds the core in reset until a clean load.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHKSUM_EN.
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  wren_o,
  output logic [ADDR_WIDTH-1:0] wraddr_o,
  output logic [DATA_WIDTH-1:0] wrdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  load_error_o,
  output logic                  cpu_hold_o
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [KW-1:0]         K_LAST  = KW'(BPW - 1);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_L = (ADDR_WIDTH + 2)'(DATA_DEPTH);

`ifdef IMEM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FIN   = 3'd4
  } state_e;
`endif

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remain_q, remain_d;
  logic [KW-1:0]           k_q, k_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]   wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    load_error_q, load_error_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic [ADDR_WIDTH+1:0]   range_end_s;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  assign range_end_s = {2'b00, base_addr_i} + {1'b0, word_count_i};

  // Next-state and registered-output decode; outputs follow the state being entered.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    k_d          = k_q;
    word_d       = word_q;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;
    load_error_d = load_error_q;
    cpu_hold_d   = cpu_hold_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d       = base_addr_i;
          remain_d     = word_count_i;
          k_d          = '0;
          word_d       = '0;
          load_error_d = 1'b0;
          cpu_hold_d   = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum_d        = 8'h00;
`endif
          if (range_end_s > DEPTH_L) begin
            load_error_d = 1'b1;
            state_d      = ST_FIN;
          end else if (word_count_i == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid_i && in_ready_q) begin
          word_d[{k_q, 3'b000} +: 8] = in_data_i;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum_d = sum8(sum_q, in_data_i);
`endif
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_WRITE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == (ADDR_WIDTH + 1)'(1)) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_FIN;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_CHECK: begin
        if (in_valid_i && in_ready_q) begin
          if (sum8(sum_q, in_data_i) != 8'h00) begin
            load_error_d = 1'b1;
          end else begin
            load_error_d = load_error_q;
          end
          state_d = ST_FIN;
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef IMEM_LOADER_CHKSUM_EN
    in_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
    in_ready_d = (state_d == ST_LOAD);
`endif
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    wren_d = (state_d == ST_WRITE);
    if (wren_d) begin
      wraddr_d = addr_q;
      wrdata_d = word_d;
    end else begin
      wraddr_d = wraddr_q;
      wrdata_d = wrdata_q;
    end
    // The core is released in the done cycle only when nothing went wrong.
    if (state_d == ST_FIN) begin
      cpu_hold_d = load_error_d;
    end else begin
      cpu_hold_d = cpu_hold_d;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      k_q          <= '0;
      word_q       <= '0;
      in_ready_q   <= 1'b0;
      wren_q       <= 1'b0;
      wraddr_q     <= '0;
      wrdata_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_error_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      k_q          <= k_d;
      word_q       <= word_d;
      in_ready_q   <= in_ready_d;
      wren_q       <= wren_d;
      wraddr_q     <= wraddr_d;
      wrdata_q     <= wrdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_error_q <= load_error_d;
      cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign in_ready_o   = in_ready_q;
  assign wren_o       = wren_q;
  assign wraddr_o     = wraddr_q;
  assign wrdata_o     = wrdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign load_error_o = load_error_q;
  assign cpu_hold_o   = cpu_hold_q;

endmodule
